// File: rtl/sdram_local_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_local_port_arbiter
// Purpose  : Shares one SDRAM controller local command port between two
//            masters. Round-robin command arbitration, grant held across
//            write bursts, in-order read tag FIFO steers read data back to
//            the master that issued each read.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_local_port_arbiter #(
    parameter int ADDR_W   = 26,
    parameter int DATA_W   = 32,
    parameter int BE_W     = 4,
    parameter int SIZE_W   = 3,
    parameter int RD_DEPTH = 8     // power of 2, at least 2
) (
    input  logic              clk,
    input  logic              reset,
    // master 0
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [BE_W-1:0]   m0_be,
    input  logic [SIZE_W-1:0] m0_size,
    input  logic              m0_burstbegin,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rdata_valid,
    // master 1
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [BE_W-1:0]   m1_be,
    input  logic [SIZE_W-1:0] m1_size,
    input  logic              m1_burstbegin,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rdata_valid,
    // controller local port
    output logic [ADDR_W-1:0] local_address,
    output logic              local_read_req,
    output logic              local_write_req,
    output logic [DATA_W-1:0] local_wdata,
    output logic [BE_W-1:0]   local_be,
    output logic [SIZE_W-1:0] local_size,
    output logic              local_burstbegin,
    input  logic              local_ready,
    input  logic [DATA_W-1:0] local_rdata,
    input  logic              local_rdata_valid,
    input  logic              local_init_done,
    output logic              rd_unexpected
);

    localparam int c_PTR_W = $clog2(RD_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TAG_W = SIZE_W + 1;   // {owner, size}

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(RD_DEPTH);
    localparam logic [SIZE_W-1:0]  c_SZ_ONE  = 1;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WR_BURST = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                pref_q, pref_d;        // master preferred on a tie
    logic                owner_q, owner_d;      // burst owner while locked
    logic [SIZE_W-1:0]   beats_q, beats_d;      // write beats still to come
    logic [c_PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [c_CNT_W-1:0]  count_q;
    logic [SIZE_W-1:0]   rbeat_q;               // read beats seen for head tag
    logic                unexp_q;
    logic [c_TAG_W-1:0]  tag_q [RD_DEPTH];

    logic                w_win;
    logic                w_grant;
    logic                w_wr;
    logic                w_rd;
    logic [SIZE_W-1:0]   w_sz;
    logic                w_full;
    logic                w_empty;
    logic                w_rd_req;
    logic                w_wr_req;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_rbeat;
    logic [c_TAG_W-1:0]  w_head;
    logic                w_head_owner;
    logic [SIZE_W-1:0]   w_head_size;
    logic [SIZE_W-1:0]   w_rbeat_inc;
    logic [SIZE_W-1:0]   w_push_size;

    assign w_full  = (count_q == c_CNT_FULL);
    assign w_empty = (count_q == '0);

    // Winner selection and command handshake; purely combinational so the
    // local port sees the winning command in the same cycle it is presented.
    always_comb begin
        w_win    = 1'b0;
        w_grant  = 1'b0;
        w_rd_req = 1'b0;
        w_wr_req = 1'b0;
        w_accept = 1'b0;
        if (state_q == S_WR_BURST) begin
            w_win   = owner_q;
            w_grant = ~reset;
        end else if (local_init_done && !reset) begin
            if ((m0_read | m0_write) && (m1_read | m1_write)) begin
                w_win = pref_q;
            end else begin
                w_win = m1_read | m1_write;
            end
            w_grant = m0_read | m0_write | m1_read | m1_write;
        end
        w_wr = w_win ? m1_write : m0_write;
        w_rd = w_win ? m1_read  : m0_read;
        w_sz = w_win ? m1_size  : m0_size;
        // a simultaneous read+write is a write; reads stall while tags are full
        w_wr_req = w_grant & w_wr;
        if (state_q == S_IDLE) begin
            w_rd_req = w_grant & ~w_wr & w_rd & ~w_full;
        end
        w_accept = local_ready & (w_wr_req | w_rd_req);
    end

    assign local_address    = w_win ? m1_address : m0_address;
    assign local_wdata      = w_win ? m1_wdata   : m0_wdata;
    assign local_be         = w_win ? m1_be      : m0_be;
    assign local_size       = w_sz;
    assign local_read_req   = w_rd_req;
    assign local_write_req  = w_wr_req;
    assign local_burstbegin = w_grant & (state_q == S_IDLE) &
                              (w_win ? m1_burstbegin : m0_burstbegin);
    assign m0_waitrequest   = ~(w_accept & ~w_win);
    assign m1_waitrequest   = ~(w_accept &  w_win);

    // Read return steering from the oldest outstanding tag.
    assign w_head       = tag_q[rd_ptr_q];
    assign w_head_owner = w_head[SIZE_W];
    assign w_head_size  = w_head[SIZE_W-1:0];
    assign w_rbeat      = local_rdata_valid & ~w_empty;
    assign w_rbeat_inc  = rbeat_q + c_SZ_ONE;
    assign w_pop        = w_rbeat & (w_rbeat_inc == w_head_size);
    assign w_push       = w_accept & w_rd_req;
    assign w_push_size  = (w_sz == '0) ? c_SZ_ONE : w_sz;

    assign m0_rdata       = local_rdata;
    assign m1_rdata       = local_rdata;
    assign m0_rdata_valid = w_rbeat & ~w_head_owner;
    assign m1_rdata_valid = w_rbeat &  w_head_owner;
    assign rd_unexpected  = unexp_q;

    // Next-state logic: burst locking and round-robin pointer update.
    always_comb begin
        state_d = state_q;
        pref_d  = pref_q;
        owner_d = owner_q;
        beats_d = beats_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_wr_req && (w_sz > c_SZ_ONE)) begin
                        state_d = S_WR_BURST;
                        owner_d = w_win;
                        beats_d = w_sz - c_SZ_ONE;
                    end else begin
                        pref_d = ~w_win;
                    end
                end
            end
            S_WR_BURST: begin
                if (w_accept) begin
                    beats_d = beats_q - c_SZ_ONE;
                    if (beats_q == c_SZ_ONE) begin
                        state_d = S_IDLE;
                        pref_d  = ~owner_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers, tag FIFO pointers and read-beat bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pref_q   <= 1'b0;
            owner_q  <= 1'b0;
            beats_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rbeat_q  <= '0;
            unexp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pref_q  <= pref_d;
            owner_q <= owner_d;
            beats_q <= beats_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
                rbeat_q  <= '0;
            end else if (w_rbeat) begin
                rbeat_q  <= w_rbeat_inc;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_CNT_ONE;
                2'b01:   count_q <= count_q - c_CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (local_rdata_valid && w_empty) begin
                unexp_q <= 1'b1;
            end
        end
    end

    // Tag storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            tag_q[wr_ptr_q] <= {w_win, w_push_size};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_local_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_local_port_arbiter
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            compared every cycle against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_local_port_arbiter;

    localparam int ADDR_W   = 26;
    localparam int DATA_W   = 32;
    localparam int BE_W     = 4;
    localparam int SIZE_W   = 3;
    localparam int RD_DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] m_addr [2];
    logic              m_rd   [2];
    logic              m_wr   [2];
    logic [DATA_W-1:0] m_wdata[2];
    logic [BE_W-1:0]   m_be   [2];
    logic [SIZE_W-1:0] m_sz   [2];
    logic              m_bb   [2];
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              m0_rdata_valid, m1_rdata_valid;
    logic [ADDR_W-1:0] local_address;
    logic              local_read_req, local_write_req;
    logic [DATA_W-1:0] local_wdata;
    logic [BE_W-1:0]   local_be;
    logic [SIZE_W-1:0] local_size;
    logic              local_burstbegin;
    logic              local_ready;
    logic [DATA_W-1:0] local_rdata;
    logic              local_rdata_valid;
    logic              local_init_done;
    logic              rd_unexpected;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sdram_local_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
        .SIZE_W(SIZE_W), .RD_DEPTH(RD_DEPTH)
    ) u_dut (
        .clk(clk), .reset(reset),
        .m0_address(m_addr[0]), .m0_read(m_rd[0]), .m0_write(m_wr[0]),
        .m0_wdata(m_wdata[0]), .m0_be(m_be[0]), .m0_size(m_sz[0]),
        .m0_burstbegin(m_bb[0]), .m0_waitrequest(m0_waitrequest),
        .m0_rdata(m0_rdata), .m0_rdata_valid(m0_rdata_valid),
        .m1_address(m_addr[1]), .m1_read(m_rd[1]), .m1_write(m_wr[1]),
        .m1_wdata(m_wdata[1]), .m1_be(m_be[1]), .m1_size(m_sz[1]),
        .m1_burstbegin(m_bb[1]), .m1_waitrequest(m1_waitrequest),
        .m1_rdata(m1_rdata), .m1_rdata_valid(m1_rdata_valid),
        .local_address(local_address), .local_read_req(local_read_req),
        .local_write_req(local_write_req), .local_wdata(local_wdata),
        .local_be(local_be), .local_size(local_size),
        .local_burstbegin(local_burstbegin), .local_ready(local_ready),
        .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
        .local_init_done(local_init_done), .rd_unexpected(rd_unexpected)
    );

    // ---------------- reference model state ----------------
    int q_own[$];          // owner of each outstanding read, oldest first
    int q_sz[$];           // beats expected for each outstanding read
    bit locked;            // a write burst holds the port
    int owner;
    int left;              // burst beats still to come
    int pref;              // master that wins a tie
    int beats;             // beats already returned for the oldest read
    bit unexp;

    // expectations for the current cycle
    int e_win;
    bit e_acc, e_wreq, e_rreq, e_bb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q_own.delete(); q_sz.delete();
        locked = 0; owner = 0; left = 0; pref = 0; beats = 0; unexp = 0;
    endtask

    task automatic idle_inputs();
        for (int n = 0; n < 2; n++) begin
            m_addr[n] = '0; m_rd[n] = 0; m_wr[n] = 0; m_wdata[n] = '0;
            m_be[n] = '0; m_sz[n] = '0; m_bb[n] = 0;
        end
        local_ready = 1; local_rdata = '0; local_rdata_valid = 0; local_init_done = 1;
    endtask

    // Called with inputs already set just after a falling edge: checks all
    // outputs against the model, then advances the model across the next
    // rising edge and returns at the following falling edge.
    task automatic step();
        bit r0, r1, v0, v1;
        #1;
        if (reset) model_clear();
        e_win = 0; e_acc = 0; e_wreq = 0; e_rreq = 0; e_bb = 0;
        if (!reset && locked) begin
            e_win  = owner;
            e_wreq = m_wr[owner];
            e_acc  = e_wreq && local_ready;
        end else if (!reset && local_init_done) begin
            r0 = m_rd[0] || m_wr[0];
            r1 = m_rd[1] || m_wr[1];
            if (r0 || r1) begin
                e_win  = (r0 && r1) ? pref : (r1 ? 1 : 0);
                e_wreq = m_wr[e_win];
                e_rreq = !m_wr[e_win] && (q_own.size() < RD_DEPTH);
                e_acc  = local_ready && (e_wreq || e_rreq);
                e_bb   = m_bb[e_win];
            end
        end
        v0 = !reset && local_rdata_valid && q_own.size() > 0 && q_own[0] == 0;
        v1 = !reset && local_rdata_valid && q_own.size() > 0 && q_own[0] == 1;

        check("local_read_req",  local_read_req,   e_rreq);
        check("local_write_req", local_write_req,  e_wreq);
        check("local_burstbegin", local_burstbegin, e_bb);
        check("m0_waitrequest",  m0_waitrequest,   !(e_acc && e_win == 0));
        check("m1_waitrequest",  m1_waitrequest,   !(e_acc && e_win == 1));
        check("m0_rdata_valid",  m0_rdata_valid,   v0);
        check("m1_rdata_valid",  m1_rdata_valid,   v1);
        check("rd_unexpected",   rd_unexpected,    unexp);
        if (e_wreq || e_rreq) begin
            check("local_address", local_address, m_addr[e_win]);
            check("local_size",    local_size,    m_sz[e_win]);
        end
        if (e_wreq) begin
            check("local_wdata", local_wdata, m_wdata[e_win]);
            check("local_be",    local_be,    m_be[e_win]);
        end
        if (v0) check("m0_rdata", m0_rdata, local_rdata);
        if (v1) check("m1_rdata", m1_rdata, local_rdata);

        @(posedge clk);
        if (!reset) begin
            if (local_rdata_valid) begin
                if (q_own.size() == 0) begin
                    unexp = 1;
                end else begin
                    beats++;
                    if (beats == q_sz[0]) begin
                        void'(q_own.pop_front());
                        void'(q_sz.pop_front());
                        beats = 0;
                    end
                end
            end
            if (e_acc) begin
                if (locked) begin
                    left--;
                    if (left == 0) begin
                        locked = 0;
                        pref = 1 - owner;
                    end
                end else if (e_wreq) begin
                    if (m_sz[e_win] <= 1) begin
                        pref = 1 - e_win;
                    end else begin
                        locked = 1; owner = e_win; left = int'(m_sz[e_win]) - 1;
                    end
                end else begin
                    q_own.push_back(e_win);
                    q_sz.push_back(m_sz[e_win] == 0 ? 1 : int'(m_sz[e_win]));
                    pref = 1 - e_win;
                end
            end
        end
        @(negedge clk);
    endtask

    // Finishes any held burst and returns all outstanding reads.
    task automatic drain();
        bit done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            idle_inputs();
            if (locked) begin
                m_wr[owner] = 1; m_sz[owner] = 3'd4;
                m_wdata[owner] = $urandom;
            end
            local_rdata_valid = (q_own.size() > 0);
            local_rdata = $urandom;
            step();
            done = !locked && q_own.size() == 0;
        end
        check("drain_bound", done, 1);
        idle_inputs();
    endtask

    initial begin
        model_clear();
        idle_inputs();
        reset = 1;
        @(negedge clk);
        step(); step();
        reset = 0;
        step();

        // single read from m0 and its data beat
        m_rd[0] = 1; m_addr[0] = 26'h100; m_sz[0] = 3'd1; m_bb[0] = 1;
        step();
        idle_inputs();
        local_rdata_valid = 1; local_rdata = 32'hA5A5A5A5;
        step();
        idle_inputs();
        step();

        // both masters reading back to back: alternating grants
        for (int i = 0; i < 8; i++) begin
            for (int n = 0; n < 2; n++) begin
                m_rd[n] = 1; m_sz[n] = 3'd1; m_bb[n] = 1;
                m_addr[n] = 26'(i * 16 + n);
            end
            step();
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            local_rdata_valid = 1; local_rdata = 32'(i + 32'hC0DE0000);
            step();
        end
        idle_inputs();

        // m1 4-beat write burst while m0 keeps asking for a read
        for (int i = 0; i < 5; i++) begin
            m_rd[0] = 1; m_addr[0] = 26'h200; m_sz[0] = 3'd1; m_bb[0] = 1;
            m_wr[1] = (i < 4); m_sz[1] = 3'd4; m_bb[1] = (i == 0);
            m_addr[1] = 26'h300; m_wdata[1] = 32'(32'hBEEF0000 + i); m_be[1] = 4'hF;
            step();
        end
        idle_inputs();
        drain();

        // fill the tag FIFO, then one return beat frees a slot
        for (int i = 0; i < 10; i++) begin
            m_rd[0] = 1; m_sz[0] = 3'd1; m_bb[0] = 1; m_addr[0] = 26'(i);
            local_rdata_valid = (i == 8);
            local_rdata = 32'h12345678;
            step();
        end
        idle_inputs();
        drain();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int n = 0; n < 2; n++) begin
                int op;
                op = $urandom_range(0, 4);
                m_rd[n]    = (op == 1) || (op == 3);
                m_wr[n]    = (op == 2) || (op == 3) || (locked && owner == n && op != 0);
                m_sz[n]    = 3'($urandom_range(0, 7));
                m_bb[n]    = $urandom_range(0, 1);
                m_addr[n]  = 26'($urandom);
                m_wdata[n] = $urandom;
                m_be[n]    = 4'($urandom);
            end
            local_ready       = ($urandom_range(0, 3) != 0);
            local_init_done   = ($urandom_range(0, 15) != 0);
            local_rdata_valid = (q_own.size() > 0) && ($urandom_range(0, 2) != 0);
            local_rdata       = $urandom;
            step();
        end
        idle_inputs();
        drain();

        // data beat with nothing outstanding: dropped, sticky flag
        local_rdata_valid = 1; local_rdata = 32'hDEADBEEF;
        step();
        idle_inputs();
        step(); step();

        // calibration not done: no grants
        local_init_done = 0;
        m_rd[0] = 1; m_wr[1] = 1; m_sz[1] = 3'd2;
        step(); step();
        idle_inputs();

        // reset in the middle of a 4-beat write burst
        for (int i = 0; i < 2; i++) begin
            m_wr[0] = 1; m_sz[0] = 3'd4; m_bb[0] = (i == 0);
            m_addr[0] = 26'h400; m_wdata[0] = 32'(i);
            step();
        end
        m_wr[1] = 1; m_sz[1] = 3'd1;
        reset = 1;
        step();
        reset = 0;
        idle_inputs();
        step();
        // back in IDLE with m0 preferred: both request, m0 wins
        m_rd[0] = 1; m_sz[0] = 3'd1; m_rd[1] = 1; m_sz[1] = 3'd1;
        step();
        idle_inputs();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
